// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit (8E1 frames).
// All state is on the rising edge of clk; rst is synchronous and active-high.

module uart_tx_fifo #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        overflow,
  output logic                        uart_tx
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLK_DIV);
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLK_DIV - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            overflow_q, overflow_d;
  logic            push;
  logic            pop;
  logic [7:0]      head;

  // Transmitter state
  state_e           state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif
  logic             baud_zero;

  assign head      = mem_q[rd_ptr_q];
  assign baud_zero = (baud_q == '0);

  // FIFO next-state: push uses the registered full flag, so a write while full
  // is dropped even if a pop frees a slot on the same edge.
  always_comb begin
    push       = wr_en & ~full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en & full_q);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CntW'(FIFO_DEPTH));
    empty_d = (count_d == '0);
  end

  // FIFO control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage: no reset needed, contents are only read behind the count
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Transmitter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Transmitter next-state: bit boundaries fall on edges where baud_q is zero
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          shift_d  = head;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
          baud_d   = BaudMax;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_zero) begin
          baud_d    = BaudMax;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          baud_d = baud_q - BaudW'(1);
        end
      end
      StData: begin
        if (baud_zero) begin
          baud_d = BaudMax;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - BaudW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_zero) begin
          baud_d  = BaudMax;
          state_d = StStop;
        end else begin
          baud_d = baud_q - BaudW'(1);
        end
      end
`endif
      StStop: begin
        if (baud_zero) begin
          // Chain straight into the next start bit when more bytes are waiting
          if (count_q != '0) begin
            pop      = 1'b1;
            shift_d  = head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
            baud_d   = BaudMax;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q - BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level for the coming cycle, registered so uart_tx never glitches
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign uart_tx    = tx_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter for the RV32I SoC. It sits directly downstream of the SoC's peripheral write path and consumes bytes written by the core. It queues them in a small FIFO and serialises them onto the `uart_tx` pin as 8N1 frames, or 8E1 frames with parity. It is the producer of the top-level `uart_tx` output.

## Interface
Parameters:
- `CLK_DIV`, default 868: clock cycles per bit period (100 MHz / 115200). Legal values are ≥ 2.
- `FIFO_DEPTH`, default 8: number of byte entries. Must be a power of two and ≥ 2.

Ports:
- `clk`  input  1  single system clock; all logic is on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `wr_en`  input  1  write strobe; a byte is accepted at an edge where `wr_en & !full`.
- `wr_data`  input  8  byte to enqueue.
- `full`  output  1  registered; FIFO holds `FIFO_DEPTH` entries.
- `empty`  output  1  registered; FIFO holds 0 entries.
- `fifo_count`  output  $clog2(FIFO_DEPTH)+1  current number of entries.
- `busy`  output  1  FSM not in IDLE, meaning a frame is on the line.
- `overflow`  output  1  sticky; set by a write attempted while `full`; cleared only by `rst`.
- `uart_tx`  output  1  serial line; idles high.

Reset (synchronous, active-high, single clock `clk`):
- `uart_tx`=1, `busy`=0, `full`=0, `empty`=1, `fifo_count`=0, `overflow`=0.
- FIFO pointers are cleared; FSM goes to IDLE; baud counter is 0.

## Operation
- FIFO: circular buffer with read/write pointers of width $clog2(FIFO_DEPTH); pointers wrap modulo `FIFO_DEPTH`.
- The count updates as follows at each edge:
  - +1 on an accepted write.
  - −1 on a pop.
  - Unchanged when a write and a pop occur on the same edge.
- Write while `full` (using the registered `full`, even if a pop occurs on the same edge):
  - the byte is dropped;
  - `overflow` is set;
  - the FIFO is unchanged.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- State transitions:
  - IDLE: if `fifo_count` != 0, pop the head into the shift register, load the baud counter with CLK_DIV−1, and go to START.
  - START: drive `uart_tx`=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: drive shift[0], LSB first, for CLK_DIV cycles per bit, then shift right. After bit 7, go to PARITY or STOP.
  - PARITY: drive the even-parity bit for CLK_DIV cycles, then go to STOP.
  - STOP: drive `uart_tx`=1 for CLK_DIV cycles. At the final cycle:
    - if FIFO is non-empty, pop and go straight to START (no idle gap);
    - otherwise go to IDLE.
- Baud counter: counts down from CLK_DIV−1; a bit boundary occurs on the edge where counter==0, and the counter reloads to CLK_DIV−1.
- `uart_tx` is driven from a register and is glitch-free.
- Bytes written during a frame are transmitted in FIFO order after the current frame.

## Timing
- Write accepted at edge N with FSM in IDLE and FIFO empty:
  - `fifo_count`=1 after N;
  - pop at edge N+1, where `uart_tx` falls, `busy` rises and `fifo_count` returns to 0.
- Frame length is exactly 10·CLK_DIV cycles (11·CLK_DIV with parity), measured from the falling edge of the start bit.
- Back-to-back frames: the next start bit begins on the edge that ends the previous stop bit.
- `busy` falls on the edge ending the last stop bit when the FIFO is empty; `uart_tx` stays 1.
- `rst` asserted mid-frame:
  - at the next edge `uart_tx`=1 and the FSM is in IDLE;
  - FIFO contents are discarded;
  - the partial frame is truncated. This is acceptable and receivers resync on the next start bit.
- `wr_en` asserted together with `rst` is ignored.

## Configuration
- Macro `UART_TX_PARITY_EN`:
  - Defined: the PARITY state is compiled in, and frames are 8E1. The parity bit is the XOR of the 8 data bits, so the total count of ones over data plus parity is even.
  - Undefined: no PARITY state or logic exists, and frames are 8N1.

## Test plan
- Single byte, CLK_DIV=4, no parity:
  - write 0xA5 at edge N;
  - `uart_tx` from edge N+1 samples 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles;
  - `busy` high for exactly 40 cycles.
- Parity build, CLK_DIV=4:
  - write 0xA5: parity bit = 0, frame 44 cycles;
  - write 0x07: parity bit = 1.
- Burst of FIFO_DEPTH+1 writes on consecutive cycles while idle, FIFO_DEPTH=8:
  - the first byte is popped at once, so all 9 writes are accepted;
  - a 10th write makes `full` stay 1 and sets `overflow`;
  - the line shows 9 contiguous frames with no idle gap.
- Write and pop on the same edge: write a byte on the exact edge the STOP bit ends with 1 entry queued; `fifo_count` stays 1 and the order is preserved.
- Reset at bit 3 of the frame for 0x3C with 2 bytes queued:
  - next edge: `uart_tx`=1, `busy`=0, `fifo_count`=0, `empty`=1, `overflow`=0;
  - no further frames are sent.
- Pointer wrap: stream 20 bytes 0x00..0x13 keeping occupancy between 1 and 3; the decoded bytes equal the inputs in order.
